// File: rtl/hazard_fwd_controller.sv
// Load-use stall and ID-stage operand forwarding control for a 5-stage pipeline.
// Keeps shadow {rd, rf_en, load} slots for the EX, MEM and WB stages.
module hazard_fwd_controller #(
  parameter int LOAD_USE_STALLS = 1,
  parameter int CNT_W           = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             id_valid,
  input  logic [3:0]       id_rn,
  input  logic [3:0]       id_rm,
  input  logic [3:0]       id_rs,
  input  logic             id_use_rn,
  input  logic             id_use_rm,
  input  logic             id_use_rs,
  input  logic [3:0]       id_rd,
  input  logic             id_rf_en,
  input  logic             id_load,
  input  logic             branch_taken,
  output logic             pc_ld,
  output logic             ifid_ld,
  output logic             ifid_flush,
  output logic             idex_bubble,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b,
  output logic [1:0]       fwd_c,
  output logic             stalled,
  output logic [CNT_W-1:0] stall_cnt
);

  typedef struct packed {
    logic [3:0] rd;
    logic       rf_en;
    logic       load;
  } slot_t;

  typedef enum logic {RUN, STALL} state_t;

  localparam logic [1:0] CNT_INIT = 2'(LOAD_USE_STALLS - 1);
  localparam bit         MULTI    = (LOAD_USE_STALLS > 1);

  slot_t            r_ex, r_mem, r_wb;
  state_t           r_state;
  logic [1:0]       r_cnt;
  logic [CNT_W-1:0] r_stall_cnt;

  logic w_hz;
  logic w_ex_rn, w_ex_rm, w_ex_rs;

  // Youngest producer wins; 00 falls back to the register file.
  function automatic logic [1:0] sel(
    input logic       u,
    input logic [3:0] r,
    input slot_t      ex,
    input slot_t      mem,
    input slot_t      wb
  );
    logic [1:0] s;
    s = 2'b00;
    if (u) begin
      if (ex.rf_en && ex.rd == r)       s = 2'b01;
      else if (mem.rf_en && mem.rd == r) s = 2'b10;
      else if (wb.rf_en && wb.rd == r)  s = 2'b11;
    end
    return s;
  endfunction

  assign fwd_a = sel(id_use_rn, id_rn, r_ex, r_mem, r_wb);
  assign fwd_b = sel(id_use_rm, id_rm, r_ex, r_mem, r_wb);
  assign fwd_c = sel(id_use_rs, id_rs, r_ex, r_mem, r_wb);

  assign w_ex_rn = id_use_rn && (r_ex.rd == id_rn);
  assign w_ex_rm = id_use_rm && (r_ex.rd == id_rm);
  assign w_ex_rs = id_use_rs && (r_ex.rd == id_rs);

  assign w_hz = id_valid && r_ex.rf_en && r_ex.load &&
                (w_ex_rn || w_ex_rm || w_ex_rs);

  assign stall_cnt = r_stall_cnt;

  always_comb begin
    pc_ld       = 1'b1;
    ifid_ld     = 1'b1;
    ifid_flush  = 1'b0;
    idex_bubble = 1'b0;
    stalled     = (r_state == STALL);
    if (r_state == STALL || w_hz) begin
      pc_ld       = 1'b0;
      ifid_ld     = 1'b0;
      idex_bubble = 1'b1;
    end else begin
      ifid_flush = branch_taken;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_ex        <= '0;
      r_mem       <= '0;
      r_wb        <= '0;
      r_state     <= RUN;
      r_cnt       <= 2'd0;
      r_stall_cnt <= '0;
    end else begin
      r_mem <= r_ex;
      r_wb  <= r_mem;
      if (idex_bubble)
        r_ex <= '0;
      else
        r_ex <= {id_rd, id_rf_en & id_valid, id_load & id_valid};
      if (idex_bubble && !(&r_stall_cnt))
        r_stall_cnt <= r_stall_cnt + 1'b1;
      case (r_state)
        RUN: begin
          if (w_hz) begin
            r_cnt <= CNT_INIT;
            if (MULTI) r_state <= STALL;
          end
        end
        STALL: begin
          r_cnt <= r_cnt - 2'd1;
          if (r_cnt == 2'd1) r_state <= RUN;
        end
        default: r_state <= RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_hazard_fwd_controller.sv
// Directed bench for hazard_fwd_controller with 1-, 3-stall and 2-bit-counter builds.
// All three instances share the ID-stage stimulus.
module tb_hazard_fwd_controller;

  logic       clk;
  logic       reset;
  logic       id_valid;
  logic [3:0] id_rn, id_rm, id_rs, id_rd;
  logic       id_use_rn, id_use_rm, id_use_rs;
  logic       id_rf_en, id_load, branch_taken;

  logic        a_pc, a_ifid, a_fl, a_bub, a_st;
  logic [1:0]  a_fa, a_fb, a_fc;
  logic [15:0] a_cnt;
  logic        c_pc, c_ifid, c_fl, c_bub, c_st;
  logic [1:0]  c_fa, c_fb, c_fc;
  logic [15:0] c_cnt;
  logic        s_pc, s_ifid, s_fl, s_bub, s_st;
  logic [1:0]  s_fa, s_fb, s_fc;
  logic [1:0]  s_cnt;

  int errs;
  int checks;

  hazard_fwd_controller #(.LOAD_USE_STALLS(1), .CNT_W(16)) u1 (
    .clk(clk), .reset(reset), .id_valid(id_valid),
    .id_rn(id_rn), .id_rm(id_rm), .id_rs(id_rs),
    .id_use_rn(id_use_rn), .id_use_rm(id_use_rm), .id_use_rs(id_use_rs),
    .id_rd(id_rd), .id_rf_en(id_rf_en), .id_load(id_load),
    .branch_taken(branch_taken),
    .pc_ld(a_pc), .ifid_ld(a_ifid), .ifid_flush(a_fl),
    .idex_bubble(a_bub), .fwd_a(a_fa), .fwd_b(a_fb), .fwd_c(a_fc),
    .stalled(a_st), .stall_cnt(a_cnt)
  );

  hazard_fwd_controller #(.LOAD_USE_STALLS(3), .CNT_W(16)) u3 (
    .clk(clk), .reset(reset), .id_valid(id_valid),
    .id_rn(id_rn), .id_rm(id_rm), .id_rs(id_rs),
    .id_use_rn(id_use_rn), .id_use_rm(id_use_rm), .id_use_rs(id_use_rs),
    .id_rd(id_rd), .id_rf_en(id_rf_en), .id_load(id_load),
    .branch_taken(branch_taken),
    .pc_ld(c_pc), .ifid_ld(c_ifid), .ifid_flush(c_fl),
    .idex_bubble(c_bub), .fwd_a(c_fa), .fwd_b(c_fb), .fwd_c(c_fc),
    .stalled(c_st), .stall_cnt(c_cnt)
  );

  hazard_fwd_controller #(.LOAD_USE_STALLS(1), .CNT_W(2)) us (
    .clk(clk), .reset(reset), .id_valid(id_valid),
    .id_rn(id_rn), .id_rm(id_rm), .id_rs(id_rs),
    .id_use_rn(id_use_rn), .id_use_rm(id_use_rm), .id_use_rs(id_use_rs),
    .id_rd(id_rd), .id_rf_en(id_rf_en), .id_load(id_load),
    .branch_taken(branch_taken),
    .pc_ld(s_pc), .ifid_ld(s_ifid), .ifid_flush(s_fl),
    .idex_bubble(s_bub), .fwd_a(s_fa), .fwd_b(s_fb), .fwd_c(s_fc),
    .stalled(s_st), .stall_cnt(s_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic setid(
    input logic v,
    input logic [3:0] rn, input logic [3:0] rm, input logic [3:0] rs,
    input logic un, input logic um, input logic us_,
    input logic [3:0] rd, input logic rf, input logic ld, input logic br
  );
    id_valid = v;
    id_rn = rn; id_rm = rm; id_rs = rs;
    id_use_rn = un; id_use_rm = um; id_use_rs = us_;
    id_rd = rd; id_rf_en = rf; id_load = ld;
    branch_taken = br;
  endtask

  task automatic clr();
    setid(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  initial begin
    errs = 0;
    checks = 0;
    reset = 1'b1;
    clr();
    tick();
    tick();
    reset = 1'b0;
    #1;
    chk("rst_pc_ld", a_pc, 1);
    chk("rst_ifid_ld", a_ifid, 1);
    chk("rst_flush", a_fl, 0);
    chk("rst_bubble", a_bub, 0);
    chk("rst_fwd_a", a_fa, 0);
    chk("rst_fwd_b", a_fb, 0);
    chk("rst_fwd_c", a_fc, 0);
    chk("rst_stalled", a_st, 0);
    chk("rst_stall_cnt", a_cnt, 0);

    // ADD r3,r1,r2 then SUB r4,r3,r1
    setid(1, 1, 2, 0, 1, 1, 0, 3, 1, 0, 0);
    tick();
    setid(1, 3, 1, 0, 1, 1, 0, 4, 1, 0, 0);
    #1;
    chk("alu_fwd_a", a_fa, 1);
    chk("alu_fwd_b", a_fb, 0);
    chk("alu_no_stall", a_pc, 1);
    tick();
    clr();
    tick(); tick(); tick();

    // LDR r5 then ADD r6,r5,r5 with one bubble
    setid(1, 0, 0, 0, 0, 0, 0, 5, 1, 1, 0);
    tick();
    setid(1, 5, 5, 0, 1, 1, 0, 6, 1, 0, 0);
    #1;
    chk("lu1_pc_ld", a_pc, 0);
    chk("lu1_ifid_ld", a_ifid, 0);
    chk("lu1_bubble", a_bub, 1);
    chk("lu1_stalled", a_st, 0);
    tick();
    #1;
    chk("lu1_fwd_a", a_fa, 2);
    chk("lu1_fwd_b", a_fb, 2);
    chk("lu1_stall_cnt", a_cnt, 1);
    chk("lu1_release", a_pc, 1);
    clr();
    tick(); tick(); tick(); tick();

    // LDR r2 then STR rs=r2 with three bubbles
    reset = 1'b1;
    tick();
    reset = 1'b0;
    setid(1, 0, 0, 0, 0, 0, 0, 2, 1, 1, 0);
    tick();
    setid(1, 0, 0, 2, 0, 0, 1, 0, 0, 0, 0);
    #1;
    chk("lu3_c1_bubble", c_bub, 1);
    chk("lu3_c1_stalled", c_st, 0);
    chk("lu3_c1_pc_ld", c_pc, 0);
    tick();
    #1;
    chk("lu3_c2_stalled", c_st, 1);
    chk("lu3_c2_bubble", c_bub, 1);
    chk("lu3_c2_fwd_c", c_fc, 2);
    tick();
    #1;
    chk("lu3_c3_stalled", c_st, 1);
    chk("lu3_c3_bubble", c_bub, 1);
    chk("lu3_c3_fwd_c", c_fc, 3);
    tick();
    #1;
    chk("lu3_c4_stalled", c_st, 0);
    chk("lu3_c4_pc_ld", c_pc, 1);
    chk("lu3_c4_bubble", c_bub, 0);
    chk("lu3_c4_fwd_c", c_fc, 0);
    chk("lu3_stall_cnt", c_cnt, 3);
    clr();
    tick(); tick(); tick(); tick();

    // r7 written by EX, MEM and WB at once
    setid(1, 0, 0, 0, 0, 0, 0, 7, 1, 0, 0);
    tick(); tick(); tick();
    setid(1, 0, 7, 0, 0, 1, 0, 0, 0, 0, 0);
    #1;
    chk("prio_ex", a_fb, 1);
    chk("prio_no_stall", a_bub, 0);
    id_use_rm = 1'b0;
    #1;
    chk("prio_unused", a_fb, 0);
    tick();
    setid(0, 0, 7, 0, 0, 1, 0, 0, 0, 0, 0);
    #1;
    chk("prio_mem", a_fb, 2);
    tick();
    #1;
    chk("prio_wb", a_fb, 3);
    tick();
    #1;
    chk("prio_rf", a_fb, 0);
    clr();
    tick(); tick(); tick();

    // Load-use with a taken branch held in ID
    setid(1, 0, 0, 0, 0, 0, 0, 5, 1, 1, 0);
    tick();
    setid(1, 5, 0, 0, 1, 0, 0, 0, 0, 0, 1);
    #1;
    chk("br1_c1_flush", a_fl, 0);
    chk("br1_c1_bubble", a_bub, 1);
    chk("br3_c1_flush", c_fl, 0);
    tick();
    #1;
    chk("br1_c2_flush", a_fl, 1);
    chk("br1_c2_pc_ld", a_pc, 1);
    chk("br3_c2_flush", c_fl, 0);
    chk("br3_c2_stalled", c_st, 1);
    tick();
    #1;
    chk("br3_c3_flush", c_fl, 0);
    chk("br3_c3_stalled", c_st, 1);
    tick();
    #1;
    chk("br3_c4_flush", c_fl, 1);
    chk("br3_c4_stalled", c_st, 0);
    clr();
    tick(); tick(); tick(); tick();

    // Reset asserted while stalled
    setid(1, 0, 0, 0, 0, 0, 0, 5, 1, 1, 0);
    tick();
    setid(1, 5, 0, 0, 1, 0, 0, 0, 0, 0, 1);
    tick();
    #1;
    chk("rs_pre_stalled", c_st, 1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    clr();
    #1;
    chk("rs_pc_ld", c_pc, 1);
    chk("rs_stalled", c_st, 0);
    chk("rs_fwd_a", c_fa, 0);
    chk("rs_fwd_b", c_fb, 0);
    chk("rs_fwd_c", c_fc, 0);
    chk("rs_flush", c_fl, 0);
    chk("rs_stall_cnt", c_cnt, 0);

    // Two-bit counter saturates at 3
    for (int i = 0; i < 5; i++) begin
      setid(1, 0, 0, 0, 0, 0, 0, 5, 1, 1, 0);
      tick();
      setid(1, 5, 0, 0, 1, 0, 0, 6, 1, 0, 0);
      tick();
      clr();
      tick();
      #1;
      chk($sformatf("sat_%0d", i), s_cnt, (i + 1 > 3) ? 3 : i + 1);
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
